// File: rtl/lock_supervisor_if.sv
// lock_supervisor_if: keypad, digital_lock and status signals around lock_supervisor
interface lock_supervisor_if #(
    parameter int MAX_FAIL = 3
);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic          key_valid;
    logic          key_bit;
    logic          lock_open;
    logic          lock_step;
    logic          lock_code;
    logic          lock_clr;
    logic          door_release;
    logic          lockout;
    logic          alarm;
    logic          busy;
    logic [FW-1:0] fail_cnt;

    modport master (
        output key_valid, key_bit, lock_open,
        input  lock_step, lock_code, lock_clr, door_release, lockout, alarm, fail_cnt, busy
    );

    modport slave (
        input  key_valid, key_bit, lock_open,
        output lock_step, lock_code, lock_clr, door_release, lockout, alarm, fail_cnt, busy
    );
endinterface

// File: rtl/lock_supervisor.sv
// lock_supervisor: groups keypad bits into digital_lock attempts, times door release, counts failures, enforces lockout and entry timeout
module lock_supervisor #(
    parameter int CODE_LEN       = 3,
    parameter int MAX_FAIL       = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 10
) (
    input logic              clk,
    input logic              reset,
    lock_supervisor_if.slave bus
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int BW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
    localparam int IW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TM = HOLD_CYCLES > LOCKOUT_CYCLES ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = TM > 1 ? $clog2(TM) : 1;

    typedef enum logic [1:0] {CLR, ENTRY, OPEN, LOCKOUT} state_t;

    state_t        state, state_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [FW-1:0] fail_cnt, fail_n;
    logic          fail;
    logic          door_release;
    logic          lockout;
    logic          alarm;

    assign bus.lock_step    = bus.key_valid & (state == ENTRY);
    assign bus.lock_code    = bus.key_bit;
    assign bus.lock_clr     = state == CLR;
    assign bus.busy         = state != ENTRY;
    assign bus.door_release = door_release;
    assign bus.lockout      = lockout;
    assign bus.alarm        = alarm;
    assign bus.fail_cnt     = fail_cnt;

    // Next state and counters; wrong code and timeout both raise fail so they share one failure path
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        idle_n  = idle_cnt;
        tmr_n   = tmr;
        fail_n  = fail_cnt;
        fail    = 1'b0;
        case (state)
            CLR: begin
                state_n = ENTRY;
                bit_n   = '0;
                idle_n  = '0;
            end
            ENTRY: begin
                if (bus.key_valid) begin
                    idle_n = '0;
                    if (bit_cnt == BW'(CODE_LEN - 1)) begin
                        if (bus.lock_open) begin
                            state_n = OPEN;
                            tmr_n   = TW'(HOLD_CYCLES - 1);
                            fail_n  = '0;
                        end else begin
                            fail = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else if (bit_cnt != '0) begin
                    if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) fail = 1'b1;
                    else idle_n = idle_cnt + 1'b1;
                end
                if (fail) begin
                    if (int'(fail_cnt) + 1 < MAX_FAIL) begin
                        fail_n  = fail_cnt + 1'b1;
                        state_n = CLR;
                    end else begin
                        fail_n  = FW'(MAX_FAIL);
                        state_n = LOCKOUT;
                        tmr_n   = TW'(LOCKOUT_CYCLES - 1);
                    end
                end
            end
            OPEN: begin
                if (tmr == '0) state_n = CLR;
                else tmr_n = tmr - 1'b1;
            end
            default: begin
                if (tmr == '0) begin
                    state_n = CLR;
                    fail_n  = '0;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
        endcase
    end

    // State, counters and registered outputs decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CLR;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            tmr          <= '0;
            fail_cnt     <= '0;
            door_release <= 1'b0;
            lockout      <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_n;
            idle_cnt     <= idle_n;
            tmr          <= tmr_n;
            fail_cnt     <= fail_n;
            door_release <= state_n == OPEN;
            lockout      <= state_n == LOCKOUT;
            alarm        <= fail;
        end
    end
endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_lock_supervisor;
    localparam int CL = 3;
    localparam int MF = 3;
    localparam int HC = 8;
    localparam int LC = 16;
    localparam int TC = 10;

    typedef struct packed {
        logic       kv;
        logic       kb;
        logic       step;
        logic       clr;
        logic       rel;
        logic       lko;
        logic       alarm;
        logic [1:0] fail;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    lock_supervisor_if #(.MAX_FAIL(MF)) bus();

    lock_supervisor #(
        .CODE_LEN(CL), .MAX_FAIL(MF), .HOLD_CYCLES(HC),
        .LOCKOUT_CYCLES(LC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for digital_lock: accepts the sequence 0,1,0, Mealy open on the final matching bit
    logic [2:0] secret = 3'b010;
    logic [1:0] lpos = 2'd0;
    logic       lok = 1'b1;

    always @(posedge clk) begin
        if (bus.lock_clr) begin
            lpos <= 2'd0;
            lok  <= 1'b1;
        end else if (bus.lock_step) begin
            lpos <= lpos + 2'd1;
            lok  <= lok & (bus.key_bit == secret[lpos]);
        end
    end

    assign bus.lock_open = bus.lock_step & lok & (bus.key_bit == secret[lpos]) & (lpos == 2'd2);

    // Behavioural model: remaining-cycle counts per phase and a count of bits in the attempt
    int m_open, m_lock, m_bits, m_idle, m_fails;
    bit m_clr, m_alarm;
    bit have_prev, pkv, plo;
    int n_pass = 0;
    int n_total = 0;
    vec_t tbl [13];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic m_reset();
        m_clr = 1; m_open = 0; m_lock = 0; m_bits = 0; m_idle = 0;
        m_fails = 0; m_alarm = 0; have_prev = 0;
    endtask

    task automatic model_step(input bit kv, input bit lo);
        bit f;
        f = 0;
        if (m_clr) begin
            m_clr = 0; m_bits = 0; m_idle = 0;
        end else if (m_open > 0) begin
            m_open--;
            if (m_open == 0) m_clr = 1;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin m_clr = 1; m_fails = 0; end
        end else if (kv) begin
            m_idle = 0;
            m_bits++;
            if (m_bits == CL) begin
                m_bits = 0;
                if (lo) begin m_open = HC; m_fails = 0; end
                else f = 1;
            end
        end else if (m_bits > 0) begin
            m_idle++;
            if (m_idle == TC) f = 1;
        end
        if (f) begin
            m_fails++; m_bits = 0; m_idle = 0;
            if (m_fails >= MF) begin m_fails = MF; m_lock = LC; end
            else m_clr = 1;
        end
        m_alarm = f;
    endtask

    task automatic check_model(input bit kv, input bit kb);
        bit entry;
        entry = !m_clr && m_open == 0 && m_lock == 0;
        chk("m_lock_step", int'(bus.lock_step), int'(kv && entry));
        chk("m_lock_code", int'(bus.lock_code), int'(kb));
        chk("m_lock_clr", int'(bus.lock_clr), int'(m_clr));
        chk("m_busy", int'(bus.busy), int'(!entry));
        chk("m_release", int'(bus.door_release), int'(m_open > 0));
        chk("m_lockout", int'(bus.lockout), int'(m_lock > 0));
        chk("m_alarm", int'(bus.alarm), int'(m_alarm));
        chk("m_fail_cnt", int'(bus.fail_cnt), m_fails);
    endtask

    task automatic cycle(input bit kv, input bit kb);
        @(negedge clk);
        if (have_prev) model_step(pkv, plo);
        bus.key_valid = kv;
        bus.key_bit = kb;
        #1;
        pkv = kv;
        plo = bus.lock_open;
        have_prev = 1;
        check_model(kv, kb);
    endtask

    task automatic rst_check();
        chk("rst_lock_clr", int'(bus.lock_clr), 1);
        chk("rst_busy", int'(bus.busy), 1);
        chk("rst_release", int'(bus.door_release), 0);
        chk("rst_lockout", int'(bus.lockout), 0);
        chk("rst_alarm", int'(bus.alarm), 0);
        chk("rst_fail_cnt", int'(bus.fail_cnt), 0);
    endtask

    initial begin
        int dens;
        bit kv;
        tbl[0] = '{1, 0, 1, 0, 0, 0, 0, 2'd0};
        tbl[1] = '{1, 1, 1, 0, 0, 0, 0, 2'd0};
        tbl[2] = '{1, 0, 1, 0, 0, 0, 0, 2'd0};
        for (int i = 3; i <= 10; i++) tbl[i] = '{1, 1, 0, 0, 1, 0, 0, 2'd0};
        tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 2'd0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 2'd0};

        bus.key_valid = 0;
        bus.key_bit = 0;
        m_reset();
        repeat (3) begin
            @(negedge clk);
            rst_check();
        end
        reset = 1;
        have_prev = 1; pkv = 0; plo = 0;

        cycle(0, 0);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_clr", int'(bus.lock_clr), 0);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].kv, tbl[i].kb);
            chk("tbl_step", int'(bus.lock_step), int'(tbl[i].step));
            chk("tbl_clr", int'(bus.lock_clr), int'(tbl[i].clr));
            chk("tbl_release", int'(bus.door_release), int'(tbl[i].rel));
            chk("tbl_lockout", int'(bus.lockout), int'(tbl[i].lko));
            chk("tbl_alarm", int'(bus.alarm), int'(tbl[i].alarm));
            chk("tbl_fail_cnt", int'(bus.fail_cnt), int'(tbl[i].fail));
        end

        for (int a = 0; a < 3; a++) begin
            repeat (3) cycle(1, 1);
            cycle(0, 0);
            chk("wrong_alarm", int'(bus.alarm), 1);
            chk("wrong_fail_cnt", int'(bus.fail_cnt), a + 1);
            chk("wrong_clr", int'(bus.lock_clr), int'(a < 2));
            chk("wrong_lockout", int'(bus.lockout), int'(a == 2));
        end
        for (int i = 0; i < 15; i++) begin
            cycle(1, 1);
            chk("lko_high", int'(bus.lockout), 1);
            chk("lko_step", int'(bus.lock_step), 0);
        end
        cycle(1, 1);
        chk("lko_end_clr", int'(bus.lock_clr), 1);
        chk("lko_end_lockout", int'(bus.lockout), 0);
        chk("lko_end_fail", int'(bus.fail_cnt), 0);

        cycle(1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0);
            chk("to_no_alarm", int'(bus.alarm), 0);
        end
        cycle(0, 0);
        chk("to_alarm", int'(bus.alarm), 1);
        chk("to_fail_cnt", int'(bus.fail_cnt), 1);
        chk("to_clr", int'(bus.lock_clr), 1);
        cycle(1, 0);
        cycle(1, 1);
        cycle(1, 0);
        cycle(0, 0);
        chk("to_open_release", int'(bus.door_release), 1);
        chk("to_open_fail", int'(bus.fail_cnt), 0);
        repeat (8) cycle(0, 0);

        cycle(1, 0);
        repeat (9) cycle(0, 0);
        cycle(1, 1);
        repeat (9) cycle(0, 0);
        cycle(1, 0);
        cycle(0, 0);
        chk("gap_release", int'(bus.door_release), 1);
        chk("gap_alarm", int'(bus.alarm), 0);
        repeat (3) cycle(0, 0);
        chk("mid_open_release", int'(bus.door_release), 1);
        reset = 0;
        #1;
        rst_check();
        m_reset();
        repeat (2) begin
            @(negedge clk);
            rst_check();
        end
        reset = 1;
        have_prev = 1; pkv = 0; plo = 0;
        cycle(0, 0);
        chk("after_mid_rst_busy", int'(bus.busy), 0);
        chk("after_mid_rst_fail", int'(bus.fail_cnt), 0);

        dens = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) dens = $urandom_range(0, 3);
            kv = dens == 0 ? ($urandom_range(0, 19) == 0) : dens == 1 ? 1'($urandom_range(0, 1)) : dens == 2 ? ($urandom_range(0, 9) != 0) : 1'b1;
            cycle(kv, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Sequencing controller for the bit-serial `digital_lock` Mealy FSM. It gates keypad bits into the lock and groups them into attempts of CODE_LEN bits. At the end of each attempt it samples the lock's open indication. It drives a timed door release, counts failed attempts, enforces a lockout window after repeated failures, and aborts stalled entries on timeout. It sits between the keypad front end and the `digital_lock` instance, and owns that instance's clear.

## Interface
- CODE_LEN, 3: key bits per attempt (≥1)
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1)
- HOLD_CYCLES, 8: cycles `release` stays high after a correct code (≥1)
- LOCKOUT_CYCLES, 16: cycles `lockout` stays high (≥1)
- TIMEOUT_CYCLES, 10: idle cycles allowed inside a started attempt (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- key_valid  in  1  key bit present this cycle
- key_bit  in  1  key bit value
- lock_open  in  1  `openlock` from digital_lock (combinational Mealy output)
- lock_step  out  1  lock may consume `lock_code` this cycle; combinational: key_valid & (state==ENTRY)
- lock_code  out  1  combinational copy of key_bit
- lock_clr  out  1  clear to digital_lock, returns it to its initial state; decode of state==CLR
- release  out  1  door release
- lockout  out  1  lockout active
- alarm  out  1  one-cycle pulse per failed attempt
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures
- busy  out  1  state != ENTRY

## Operation
- States: CLR, ENTRY, OPEN, LOCKOUT. Internal counters:
  - bit_cnt, 0..CODE_LEN-1
  - idle_cnt, 0..TIMEOUT_CYCLES-1
  - tmr, shared by OPEN and LOCKOUT
- CLR: lock_clr=1, keys ignored. Lasts exactly 1 cycle, then ENTRY with bit_cnt=0 and idle_cnt=0.
- ENTRY:
  - Accepted bit = key_valid=1. Each accepted bit sets idle_cnt to 0.
  - If the bit is not the last, bit_cnt increments.
  - Last bit (bit_cnt==CODE_LEN-1) ends the attempt. lock_open is sampled in that same cycle.
  - lock_open=1 gives success: go to OPEN with tmr=HOLD_CYCLES-1 and fail_cnt=0.
  - lock_open=0 gives failure (see below).
  - While bit_cnt>0 and key_valid=0, idle_cnt increments. When idle_cnt would reach TIMEOUT_CYCLES, the attempt fails and lock_open is ignored.
  - With bit_cnt==0, idle time is unlimited.
- Failure:
  - alarm=1 for the next cycle.
  - If fail_cnt+1 < MAX_FAIL: fail_cnt increments, go to CLR.
  - Otherwise: fail_cnt=MAX_FAIL, go to LOCKOUT with tmr=LOCKOUT_CYCLES-1.
- OPEN:
  - release=1, keys ignored.
  - tmr decrements each cycle. At tmr==0, go to CLR.
- LOCKOUT:
  - lockout=1, keys ignored.
  - tmr decrements each cycle. At tmr==0, go to CLR and clear fail_cnt.
- Registered outputs: release, lockout and alarm are registered, and equal the state decode and pulse described above.
- Arithmetic: all counters are unsigned. No wrap: every terminal condition is checked before increment or decrement. fail_cnt saturates at MAX_FAIL.

## Timing
- Reset (reset=0, asynchronous) values:
  - state=CLR, so lock_clr=1 and busy=1
  - release=0, lockout=0, alarm=0, fail_cnt=0
  - all counters 0
- First rising edge after reset deasserts moves CLR to ENTRY. The earliest key accepted is in the second cycle after deassertion.
- Attempt-end edge to the first release=1 cycle: 1 cycle. release is high for exactly HOLD_CYCLES cycles, then lock_clr is high for 1 cycle.
- Failure edge:
  - alarm and the fail_cnt update appear 1 cycle later.
  - On non-lockout failure, lock_clr is high in that same cycle, and the next attempt may start the following cycle.
- Lockout: high for exactly LOCKOUT_CYCLES cycles, then CLR for 1 cycle. fail_cnt reads 0 from the CLR cycle onward.
- Keys presented while busy=1 are dropped: lock_step=0, and bit_cnt and idle_cnt are unchanged.
- Timeout boundary: the last bit arriving in the cycle idle_cnt would reach TIMEOUT_CYCLES counts as a valid bit. The timeout fires only on key_valid=0.
- Asynchronous reset mid-OPEN or mid-LOCKOUT forces the reset values immediately. No release or lockout glitch beyond the assertion edge.

## Test plan
- Reset: hold reset=0 for 3 cycles.
  - During reset: lock_clr=1, busy=1, release=0, lockout=0, alarm=0, fail_cnt=0.
  - 1 cycle after deassertion: busy=0, lock_clr=0.
- Correct code: bits 0,1,0 on consecutive cycles, with a lock model asserting lock_open on the third bit.
  - release=1 for exactly 8 cycles starting 1 cycle after the third bit.
  - Then lock_clr=1 for 1 cycle; fail_cnt=0.
- Three wrong codes: three attempts of 1,1,1 with lock_open=0.
  - alarm pulses 3 times; fail_cnt goes 1, 2, 3.
  - lockout=1 for 16 cycles, and lock_step=0 with key_valid held 1.
  - Then lock_clr for 1 cycle; fail_cnt=0.
- Timeout: bit 0, then key_valid=0 for 10 cycles.
  - alarm=1 once, fail_cnt=1, lock_clr=1 for 1 cycle.
  - A following correct 0,1,0 opens and sets fail_cnt=0.
- Gaps: 0, idle 9 cycles, 1, idle 9 cycles, 0 with lock_open on the last bit → no timeout; release for 8 cycles.
- Reset mid-OPEN: assert reset at release cycle 4.
  - release=0 and lock_clr=1 immediately (asynchronous).
  - After deassertion: normal ENTRY, fail_cnt=0.
